serial_word_receiver: RTL and testbench

Serial-in, parallel-out receiver that reassembles framed serial bit streams into WIDTH-bit words. It is the receiving end of the bit-serial link driven by the team's universal shift register. It supports MSB-first (left-shift) and LSB-first (right-shift) ordering, and holds each completed word in a registered output stage with a valid/ready handshake, so a new frame can shift in while the previous word waits for the consumer.

---
 rtl/serial_word_receiver_pkg.sv | 25 ++
 rtl/serial_word_out_stage.sv | 49 ++++
 rtl/serial_word_receiver.sv | 125 ++++++++++++
 tb/tb_serial_word_receiver.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_word_receiver_pkg.sv
// ============================================================================
// Module : serial_word_receiver_pkg
// Brief  : Shared FSM state encoding and bit-counter sizing for the receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package serial_word_receiver_pkg;

    localparam int c_default_width = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_t;

    // Bits needed to hold a count of 0..width inclusive.
    function automatic int bit_cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/serial_word_out_stage.sv
// ============================================================================
// Module : serial_word_out_stage
// Brief  : Output holding register with valid/ready handshake and sticky overrun.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_word_out_stage #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             commit,
    input  logic [WIDTH-1:0] word,
    input  logic             parity_err,
    input  logic             o_ready,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    output logic             overrun,
    output logic             perr
);

    logic w_accept;

    // A slot is free when empty or being drained on this same edge.
    assign w_accept = ~o_valid | o_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            o       <= '0;
            o_valid <= 1'b0;
            overrun <= 1'b0;
            perr    <= 1'b0;
        end else if (commit) begin
            if (w_accept) begin
                o       <= word;
                perr    <= parity_err;
                o_valid <= 1'b1;
            end else begin
                overrun <= 1'b1;
            end
        end else if (o_valid && o_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/serial_word_receiver.sv
// ============================================================================
// Module : serial_word_receiver
// Brief  : Framed serial-to-parallel receiver, MSB/LSB-first, valid/ready out.
//          Optional even-parity bit enabled by SERIAL_WORD_RECEIVER_PARITY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_word_receiver
    import serial_word_receiver_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             msb_first,
    input  logic             sin,
    input  logic             sin_valid,
    output logic [WIDTH-1:0] o,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    output logic             perr
);

    localparam int c_cnt_w = bit_cnt_width(WIDTH);

    state_t             r_state, w_state_nxt;
    logic [WIDTH-1:0]   r_sreg, w_sreg_nxt, w_shifted, w_word;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic               r_msb, w_msb_nxt;
    logic               r_frame_err, w_frame_err_nxt;
    logic               w_commit, w_perr;

    assign w_shifted = r_msb ? {r_sreg[WIDTH-2:0], sin} : {sin, r_sreg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_sreg      <= '0;
            r_cnt       <= '0;
            r_msb       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sreg      <= w_sreg_nxt;
            r_cnt       <= w_cnt_nxt;
            r_msb       <= w_msb_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_sreg_nxt      = r_sreg;
        w_cnt_nxt       = r_cnt;
        w_msb_nxt       = r_msb;
        w_frame_err_nxt = 1'b0;
        w_commit        = 1'b0;
        w_word          = w_shifted;
        w_perr          = 1'b0;

        // start always wins: a frame in flight is abandoned and restarted.
        if (start) begin
            w_state_nxt     = ST_SHIFT;
            w_sreg_nxt      = '0;
            w_cnt_nxt       = '0;
            w_msb_nxt       = msb_first;
            w_frame_err_nxt = (r_state != ST_IDLE);
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    if (sin_valid) begin
                        w_sreg_nxt = w_shifted;
                        w_cnt_nxt  = r_cnt + c_cnt_w'(1);
                        if (r_cnt == c_cnt_w'(WIDTH - 1)) begin
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
                            w_state_nxt = ST_PARITY;
`else
                            w_state_nxt = ST_IDLE;
                            w_commit    = 1'b1;
`endif
                        end
                    end
                end
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
                ST_PARITY: begin
                    w_word = r_sreg;
                    if (sin_valid) begin
                        w_state_nxt = ST_IDLE;
                        w_commit    = 1'b1;
                        w_perr      = (^r_sreg) ^ sin;
                    end
                end
`endif
                ST_IDLE: ;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign busy      = (r_state != ST_IDLE);
    assign frame_err = r_frame_err;

    serial_word_out_stage #(
        .WIDTH(WIDTH)
    ) u_out_stage (
        .clk       (clk),
        .reset     (reset),
        .commit    (w_commit),
        .word      (w_word),
        .parity_err(w_perr),
        .o_ready   (o_ready),
        .o         (o),
        .o_valid   (o_valid),
        .overrun   (overrun),
        .perr      (perr)
    );

endmodule

`default_nettype wire

// File: tb/tb_serial_word_receiver.sv
// ============================================================================
// Module : tb_serial_word_receiver
// Brief  : Self-checking bench: vector table plus scoreboard of delivered words.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_serial_word_receiver;

    localparam int WIDTH = 8;
`ifdef SERIAL_WORD_RECEIVER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset, start, msb_first, sin, sin_valid, o_ready;
    logic [WIDTH-1:0] o;
    logic             o_valid, busy, overrun, frame_err, perr;

    always #5 clk = ~clk;

    serial_word_receiver #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .msb_first(msb_first),
        .sin      (sin),
        .sin_valid(sin_valid),
        .o        (o),
        .o_valid  (o_valid),
        .o_ready  (o_ready),
        .busy     (busy),
        .overrun  (overrun),
        .frame_err(frame_err),
        .perr     (perr)
    );

    // stream[7] is the first bit on the wire.
    typedef struct {
        logic       msbf;
        logic [7:0] stream;
        int         gap_pos;
        int         gap_len;
        logic       par;
        logic [7:0] exp;
    } vec_t;

    typedef struct {
        logic [7:0] word;
        logic       perr;
    } sb_t;

    sb_t  sb_q[$];
    vec_t vecs[8];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic exp_perr(input logic [7:0] w, input logic par);
        return PAR_EN ? ((^w) ^ par) : 1'b0;
    endfunction

    // Scoreboard: every handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!reset && o_valid && o_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL sb_unexpected: got %0h expected none", o);
            end else begin
                sb_t e;
                e = sb_q.pop_front();
                chk("sb_word", 32'(o), 32'(e.word));
                chk("sb_perr", 32'(perr), 32'(e.perr));
            end
        end
    end

    task automatic send_frame(input logic m, input logic [7:0] stream, input int gap_pos,
                              input int gap_len, input logic par, input logic ferr_exp);
        @(posedge clk); #1;
        start = 1'b1; msb_first = m; sin_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i == gap_pos) begin
                for (int g = 0; g < gap_len; g++) begin
                    @(posedge clk); #1;
                    start = 1'b0; sin_valid = 1'b0;
                    @(negedge clk);
                    chk("busy_gap", 32'(busy), 1);
                end
            end
            @(posedge clk); #1;
            start = 1'b0; msb_first = ~m; sin = stream[7-i]; sin_valid = 1'b1;
            if (i == 0) begin
                @(negedge clk);
                chk("frame_err_pulse", 32'(frame_err), 32'(ferr_exp));
                chk("busy_start", 32'(busy), 1);
            end
            if (i == 1) begin
                @(negedge clk);
                chk("frame_err_clear", 32'(frame_err), 0);
            end
        end
        if (PAR_EN) begin
            @(posedge clk); #1;
            sin = par; sin_valid = 1'b1;
        end
        @(posedge clk); #1;
        sin_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'b0100_1010, -1, 0, 1'b1, 8'h4A};
        vecs[1] = '{1'b0, 8'b0100_1010, -1, 0, 1'b1, 8'h52};
        vecs[2] = '{1'b1, 8'hA5,         4, 3, 1'b0, 8'hA5};
        vecs[3] = '{1'b0, 8'b1110_0000, -1, 0, 1'b1, 8'h07};
        vecs[4] = '{1'b1, 8'b1110_0000, -1, 0, 1'b1, 8'hE0};
        vecs[5] = '{1'b0, 8'b0000_0001, -1, 0, 1'b1, 8'h80};
        vecs[6] = '{1'b1, 8'hFF,        -1, 0, 1'b0, 8'hFF};
        vecs[7] = '{1'b1, 8'h4A,        -1, 0, 1'b0, 8'h4A};

        reset = 1'b1; start = 1'b0; msb_first = 1'b0; sin = 1'b0;
        sin_valid = 1'b0; o_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_o", 32'(o), 0);
        chk("rst_o_valid", 32'(o_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        chk("rst_frame_err", 32'(frame_err), 0);
        chk("rst_perr", 32'(perr), 0);
        @(posedge clk); #1;
        reset = 1'b0;

        foreach (vecs[k]) begin
            sb_q.push_back('{vecs[k].exp, exp_perr(vecs[k].exp, vecs[k].par)});
            send_frame(vecs[k].msbf, vecs[k].stream, vecs[k].gap_pos, vecs[k].gap_len,
                       vecs[k].par, 1'b0);
            @(negedge clk);
            chk("o_valid_latency", 32'(o_valid), 1);
            chk("o_word", 32'(o), 32'(vecs[k].exp));
            chk("o_perr", 32'(perr), 32'(exp_perr(vecs[k].exp, vecs[k].par)));
            chk("busy_done", 32'(busy), 0);
        end

        // Overrun: consumer stalled across two completed frames.
        @(posedge clk); #1;
        o_ready = 1'b0;
        sb_q.push_back('{8'h11, 1'b0});
        send_frame(1'b1, 8'h11, -1, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ovr_first_valid", 32'(o_valid), 1);
        chk("ovr_first_word", 32'(o), 32'h11);
        chk("ovr_not_yet", 32'(overrun), 0);
        send_frame(1'b1, 8'h22, -1, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("ovr_hold_word", 32'(o), 32'h11);
        chk("ovr_hold_valid", 32'(o_valid), 1);
        chk("ovr_sticky", 32'(overrun), 1);
        @(posedge clk); #1;
        o_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("ovr_drained", 32'(o_valid), 0);
        chk("ovr_still_set", 32'(overrun), 1);

        // Abort: 3 LSB-first bits, then a restart that re-latches MSB-first.
        @(posedge clk); #1;
        start = 1'b1; msb_first = 1'b0; sin_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
            start = 1'b0; sin = 1'b1; sin_valid = 1'b1;
        end
        sb_q.push_back('{8'h3C, exp_perr(8'h3C, 1'b0)});
        send_frame(1'b1, 8'h3C, -1, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("abort_word", 32'(o), 32'h3C);
        chk("abort_valid", 32'(o_valid), 1);

        // Reset mid-frame while a word is held: everything is lost.
        @(posedge clk); #1;
        o_ready = 1'b0;
        send_frame(1'b1, 8'h5A, -1, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("held_before_rst", 32'(o_valid), 1);
        @(posedge clk); #1;
        start = 1'b1; msb_first = 1'b1; sin_valid = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(posedge clk); #1;
            start = 1'b0; sin = 1'b0; sin_valid = 1'b1;
        end
        reset = 1'b1; start = 1'b1; o_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; sin_valid = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_o_valid", 32'(o_valid), 0);
        chk("midrst_o", 32'(o), 0);
        chk("midrst_overrun", 32'(overrun), 0);

        // Recovery after reset.
        sb_q.push_back('{8'h81, exp_perr(8'h81, 1'b0)});
        send_frame(1'b0, 8'b1000_0001, -1, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("recover_word", 32'(o), 32'h81);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
